// File: rtl/fwd_pkg.sv
// Shared types and helpers for the operand-forwarding / load-use hazard unit.
package fwd_pkg;

    // Widest register address any instance may use; narrower tags are zero-extended.
    localparam int TAG_AW_MAX = 8;

    // Forward-select encodings: 0 reads the regfile, k takes stage k's result.
    localparam int FWD_RF    = 0;
    localparam int FWD_EXMEM = 1;
    localparam int FWD_MEMWB = 2;

    // One in-flight destination tag.
    typedef struct packed {
        logic                  vld;
        logic [TAG_AW_MAX-1:0] rd;
        logic                  ld;
    } tag_entry_t;

    // Width of a forward select able to encode 0..depth.
    function automatic int sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Matches one source register against every in-flight tag; youngest hit wins.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int FWD_DEPTH = 3,
    parameter int ZERO_REG  = 1,
    parameter int SW        = sel_w(FWD_DEPTH)
) (
    input  tag_entry_t [FWD_DEPTH-1:0] entries_i,
    input  logic [REG_AW-1:0]          src_i,
    input  logic                       used_i,
    output logic [SW-1:0]              sel_o,
    output logic                       is_load_o
);

    logic [TAG_AW_MAX-1:0] src_ext;
    logic                  src_ok;
    logic [FWD_DEPTH-1:0]  hit;

    assign src_ext = TAG_AW_MAX'(src_i);
    // $zero is hard-wired, so forwarding it is never meaningful when ZERO_REG is set.
    assign src_ok  = used_i & ~((ZERO_REG != 0) & (src_i == '0));

    generate
        for (genvar gi = 0; gi < FWD_DEPTH; gi++) begin : g_hit
            assign hit[gi] = entries_i[gi].vld & (entries_i[gi].rd == src_ext) & src_ok;
        end
    endgenerate

    // Priority pick: scan oldest to youngest so the youngest hit overwrites.
    always_comb begin
        sel_o     = '0;
        is_load_o = 1'b0;
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (hit[k]) begin
                sel_o     = SW'(k + 1);
                is_load_o = entries_i[k].ld;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding and load-use hazard unit: tag pipeline, registered
// forward selects for EX, combinational stall and a saturating stall counter.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int FWD_DEPTH = 3,
    parameter int LOAD_LAT  = 1,
    parameter int ZERO_REG  = 1,
    parameter int CNT_W     = 16,
    localparam int SW       = sel_w(FWD_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wr_en,
    input  logic              id_is_load,
    input  logic              flush,
    output logic              stall,
    output logic [SW-1:0]     fwd_sel_a,
    output logic [SW-1:0]     fwd_sel_b,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Index 0 holds the EX-stage tag (stage 1), index FWD_DEPTH-1 the oldest.
    tag_entry_t [FWD_DEPTH-1:0] tags_q, tags_d;
    logic [SW-1:0]    sel_a_q, sel_a_d, sel_b_q, sel_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [SW-1:0] win_a, win_b;
    logic          ld_a, ld_b;
    logic          haz_a, haz_b;
    logic          squash;

    fwd_match #(
        .REG_AW(REG_AW), .FWD_DEPTH(FWD_DEPTH), .ZERO_REG(ZERO_REG), .SW(SW)
    ) u_match_rs (
        .entries_i(tags_q), .src_i(id_rs), .used_i(id_rs_used),
        .sel_o(win_a), .is_load_o(ld_a)
    );

    fwd_match #(
        .REG_AW(REG_AW), .FWD_DEPTH(FWD_DEPTH), .ZERO_REG(ZERO_REG), .SW(SW)
    ) u_match_rt (
        .entries_i(tags_q), .src_i(id_rt), .used_i(id_rt_used),
        .sel_o(win_b), .is_load_o(ld_b)
    );

    // A load is only a hazard while it is still too young to forward from;
    // a younger non-load winner already masks it inside the matcher.
    assign haz_a  = ld_a & (win_a != '0) & (win_a <= SW'(LOAD_LAT));
    assign haz_b  = ld_b & (win_b != '0) & (win_b <= SW'(LOAD_LAT));
    assign stall  = id_valid & ~flush & (haz_a | haz_b);
    assign squash = stall | flush | ~id_valid;

    // Next-state: shift tags, insert new entry or bubble, compute selects and counter.
    always_comb begin
        tags_d        = tags_q;
        tags_d[0].vld = id_valid & id_wr_en & ~flush & ~stall;
        tags_d[0].rd  = TAG_AW_MAX'(id_rd);
        tags_d[0].ld  = id_is_load & id_valid & id_wr_en & ~flush & ~stall;
        for (int k = 1; k < FWD_DEPTH; k++) begin
            tags_d[k] = tags_q[k-1];
        end
        sel_a_d = squash ? SW'(FWD_RF) : win_a;
        sel_b_d = squash ? SW'(FWD_RF) : win_b;
        cnt_d   = cnt_q;
        if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers; reset drops every in-flight tag immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tags_q  <= '0;
            sel_a_q <= '0;
            sel_b_q <= '0;
            cnt_q   <= '0;
        end else begin
            tags_q  <= tags_d;
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fwd_sel_a = sel_a_q;
    assign fwd_sel_b = sel_b_q;
    assign stall_cnt = cnt_q;

endmodule
